scenario_state_monitor: RTL and testbench

SCENARIO_STATE_MONITOR -- requirements
Module: scenario_state_monitor

---
 rtl/scenario_state_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_scenario_state_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scenario_state_monitor.sv
// Watches a scenario FSM state code, classifies each transition as legal or illegal,
// queues transition events with dwell times in a FWFT FIFO and keeps saturating counters.
module scenario_state_monitor #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DWELL_W    = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         scenario_state,
    input  logic               clear,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [DWELL_W+8:0] evt_data,
    output logic [15:0]        trans_count,
    output logic [7:0]         illegal_count,
    output logic               overflow,
    output logic               seq_done
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [3:0]  ST_IDLE = 4'd0;
    localparam logic [3:0]  ST_LAST = 4'd8;

    typedef struct packed {
        logic               illegal;
        logic [3:0]         prev;
        logic [3:0]         nxt;
        logic [DWELL_W-1:0] dwell;
    } evt_t;

    typedef enum logic {
        TRK_OFF,
        TRK_ARMED
    } trk_e;

    logic [3:0]         state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    evt_t               data_q, data_d;
    logic [15:0]        trans_q, trans_d;
    logic [7:0]         illegal_q, illegal_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    trk_e               trk_q, trk_d;
    logic [3:0]         step_q, step_d;

    evt_t               mem [FIFO_DEPTH];

    logic [3:0]         code_c;
    logic               trans_c;
    logic               legal_c;
    logic               full_c;
    logic               pop_c;
    logic               push_c;
    logic               push_ok_c;
    logic [DWELL_W-1:0] dwell_inc_c;
    evt_t               evt_c;
    logic               unused_c;

    assign code_c      = scenario_state[3:0];
    assign unused_c    = ^scenario_state[7:4];
    assign full_c      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop_c       = valid_q && evt_ready;
    assign trans_c     = (code_c != state_q);
    assign dwell_inc_c = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);
    // Forward step n -> n+1, or any valid code back to IDLE (covers 8 -> 0 and aborts)
    assign legal_c     = (state_q <= ST_LAST) && (code_c <= ST_LAST) &&
                         ((code_c == ST_IDLE) || (code_c == state_q + 4'd1));

    always_comb begin
        evt_c.illegal = !legal_c;
        evt_c.prev    = state_q;
        evt_c.nxt     = code_c;
        evt_c.dwell   = dwell_inc_c;
    end

    // Next-state logic for monitor state, counters, tracker and FIFO pointers
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        trans_d   = trans_q;
        illegal_d = illegal_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        trk_d     = trk_q;
        step_d    = step_q;
        push_c    = 1'b0;
        push_ok_c = 1'b0;

        if (clear) begin
            state_d   = code_c;
            dwell_d   = '0;
            rd_d      = '0;
            wr_d      = '0;
            cnt_d     = '0;
            trans_d   = '0;
            illegal_d = '0;
            ovf_d     = 1'b0;
            trk_d     = (code_c == ST_IDLE) ? TRK_ARMED : TRK_OFF;
            step_d    = '0;
        end else begin
            if (trans_c) begin
                state_d = code_c;
                dwell_d = '0;
                push_c  = 1'b1;
                if (trans_q != '1) begin
                    trans_d = trans_q + 16'd1;
                end
                if (!legal_c && (illegal_q != '1)) begin
                    illegal_d = illegal_q + 8'd1;
                end
                // Sequence tracker: arms on every legal entry to IDLE, counts in-order steps
                if (!legal_c) begin
                    trk_d  = TRK_OFF;
                    step_d = '0;
                end else if (code_c == ST_IDLE) begin
                    done_d = (trk_q == TRK_ARMED) && (state_q == ST_LAST) && (step_q == ST_LAST);
                    trk_d  = TRK_ARMED;
                    step_d = '0;
                end else if ((trk_q == TRK_ARMED) && (step_q == state_q)) begin
                    step_d = step_q + 4'd1;
                end else begin
                    trk_d  = TRK_OFF;
                    step_d = '0;
                end
            end else begin
                dwell_d = dwell_inc_c;
            end

            push_ok_c = push_c && (!full_c || pop_c);
            if (push_c && !push_ok_c) begin
                ovf_d = 1'b1;
            end
            if (pop_c) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (push_ok_c) begin
                wr_d = wr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        end
    end

    // Head register: bypass the incoming event when it lands at the new read slot
    always_comb begin
        valid_d = (cnt_d != '0);
        data_d  = (push_ok_c && (wr_q == rd_d)) ? evt_c : mem[rd_d];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            dwell_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            trans_q   <= '0;
            illegal_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            trk_q     <= TRK_ARMED;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            trans_q   <= trans_d;
            illegal_q <= illegal_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            trk_q     <= trk_d;
            step_q    <= step_d;
        end
    end

    // Event storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clock) begin
        if (push_ok_c) begin
            mem[wr_q] <= evt_c;
        end
    end

    assign evt_valid     = valid_q;
    assign evt_data      = data_q;
    assign trans_count   = trans_q;
    assign illegal_count = illegal_q;
    assign overflow      = ovf_q;
    assign seq_done      = done_q;

endmodule

// File: tb/tb_scenario_state_monitor.sv
// Directed bench for scenario_state_monitor: expected events are queued as stimulus is
// driven and compared in order as the DUT hands them out.
module tb_scenario_state_monitor;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned EW    = DW + 9;

    logic          clock;
    logic          reset_n;
    logic [7:0]    scenario_state;
    logic          clear;
    logic          evt_valid;
    logic          evt_ready;
    logic [EW-1:0] evt_data;
    logic [15:0]   trans_count;
    logic [7:0]    illegal_count;
    logic          overflow;
    logic          seq_done;

    int            n_cmp;
    int            n_mis;
    int            n_seq;
    int            hold_edges;
    logic [3:0]    cur;
    logic [EW-1:0] last_exp;
    logic [EW-1:0] sb [$];

    scenario_state_monitor #(
        .FIFO_DEPTH (DEPTH),
        .DWELL_W    (DW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .scenario_state (scenario_state),
        .clear          (clear),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .trans_count    (trans_count),
        .illegal_count  (illegal_count),
        .overflow       (overflow),
        .seq_done       (seq_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
        if (hold_edges < 65535) hold_edges++;
    endtask

    // Move the scenario to a new code; queue the expected event unless it should be dropped
    task automatic go(input logic [3:0] code, input int cycles, input logic ill, input logic kept);
        last_exp = {ill, cur, code, DW'(hold_edges)};
        if (kept) sb.push_back(last_exp);
        scenario_state = {4'h0, code};
        hold_edges = 0;
        cur = code;
        repeat (cycles) tick();
    endtask

    // Output monitor: count seq_done pulses and score every accepted event
    initial begin
        logic [EW-1:0] exp;
        forever begin
            @(negedge clock);
            if (seq_done) n_seq++;
            if (evt_valid && evt_ready) begin
                check("evt_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("evt_data", 32'(evt_data), 32'(exp));
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_mis = 0; n_seq = 0; hold_edges = 0;
        cur = 4'd0; last_exp = '0;
        reset_n = 1'b0; scenario_state = 8'h00; clear = 1'b0; evt_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_trans", 32'(trans_count), 32'd0);
        check("rst_illegal", 32'(illegal_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        reset_n = 1'b1;
        hold_edges = 1;

        // Full legal sequence 0 -> 1..8 -> 0
        repeat (5) tick();
        for (int c = 1; c <= 8; c++) go(4'(c), 10, 1'b0, 1'b1);
        go(4'd0, 1, 1'b0, 1'b1);
        check("seq_done_pulse", 32'(seq_done), 32'd1);
        tick();
        check("seq_done_end", 32'(seq_done), 32'd0);
        repeat (3) tick();
        check("seq_trans", 32'(trans_count), 32'd9);
        check("seq_illegal", 32'(illegal_count), 32'd0);
        check("seq_pulses", 32'(n_seq), 32'd1);
        check("seq_drained", 32'(sb.size()), 32'd0);

        // Illegal jump 0 -> 3; latency and head stability under backpressure
        check("pre_jump_valid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
        go(4'd3, 1, 1'b1, 1'b1);
        check("jump_latency", 32'(evt_valid), 32'd1);
        check("jump_data", 32'(evt_data), 32'(last_exp));
        repeat (2) tick();
        check("jump_stable", 32'(evt_data), 32'(last_exp));
        evt_ready = 1'b1;
        for (int c = 4; c <= 8; c++) go(4'(c), 3, 1'b0, 1'b1);
        go(4'd0, 4, 1'b0, 1'b1);
        check("jump_illegal", 32'(illegal_count), 32'd1);
        check("jump_trans", 32'(trans_count), 32'd16);
        check("jump_no_done", 32'(n_seq), 32'd1);

        // Clear while idle
        hold_edges = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_trans", 32'(trans_count), 32'd0);
        check("clr_illegal", 32'(illegal_count), 32'd0);

        // Fill FIFO, then push and pop on the same edge while full
        evt_ready = 1'b0;
        for (int c = 1; c <= 8; c++) go(4'(c), 2, 1'b0, 1'b1);
        check("full_valid", 32'(evt_valid), 32'd1);
        check("full_no_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        go(4'd0, 1, 1'b0, 1'b1);
        evt_ready = 1'b0;
        check("full_pushpop_ovf", 32'(overflow), 32'd0);

        // FIFO still holds eight: two more transitions are dropped
        go(4'd1, 2, 1'b0, 1'b0);
        go(4'd2, 2, 1'b0, 1'b0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_trans", 32'(trans_count), 32'd11);
        evt_ready = 1'b1;
        repeat (12) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(evt_valid), 32'd0);

        // Dwell saturation
        go(4'd3, 2, 1'b0, 1'b1);
        go(4'd4, 65600, 1'b0, 1'b1);
        go(4'd5, 1, 1'b0, 1'b1);
        check("dwell_sat", 32'(evt_data), 32'(last_exp));
        repeat (2) tick();

        // Clear coincident with a transition: no event, counters zeroed
        hold_edges = 0;
        scenario_state = 8'h06;
        cur = 4'd6;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clrx_trans", 32'(trans_count), 32'd0);
        check("clrx_ovf", 32'(overflow), 32'd0);
        check("clrx_valid", 32'(evt_valid), 32'd0);
        repeat (3) tick();
        check("clrx_no_evt", 32'(evt_valid), 32'd0);
        go(4'd7, 3, 1'b0, 1'b1);
        go(4'd12, 2, 1'b1, 1'b1);
        go(4'd0, 4, 1'b1, 1'b1);
        check("inv_illegal", 32'(illegal_count), 32'd2);
        check("inv_trans", 32'(trans_count), 32'd3);
        check("inv_drained", 32'(sb.size()), 32'd0);

        // Reset mid-operation discards queued events; first edge after release is from IDLE
        evt_ready = 1'b0;
        go(4'd1, 2, 1'b0, 1'b1);
        go(4'd2, 2, 1'b0, 1'b1);
        check("mid_valid", 32'(evt_valid), 32'd1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_trans", 32'(trans_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        tick();
        cur = 4'd0;
        hold_edges = 1;
        go(4'd2, 0, 1'b1, 1'b1);
        reset_n = 1'b1;
        repeat (5) tick();
        check("post_rst_trans", 32'(trans_count), 32'd1);
        check("post_rst_illegal", 32'(illegal_count), 32'd1);
        check("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
